// File: rtl/hdmi_clk_source_ctrl_pkg.sv
// Shared types for the HDMI clock-source controller: FSM states, mux
// target encodings and the window range qualifier.
package clk_src_pkg;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        QUALIFY = 2'd1,
        ONLINE  = 2'd2,
        SWITCH  = 2'd3
    } state_t;

    localparam logic SRC_LOCAL = 1'b0;
    localparam logic SRC_HDMI  = 1'b1;

    function automatic logic cnt_in_range(input logic [31:0] cnt,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/hdmi_clk_source_ctrl_if.sv
// Status/control bundle between the clock-source controller and its user.
interface hdmi_clk_source_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hdmi_tgl;
    logic             hpd;
    logic             force_local;
    logic             online;
    logic             rst_out;
    logic [CNT_W-1:0] freq_cnt;
    logic             meas_valid;
    logic [2:0]       qual_cnt;

    modport master (
        output hdmi_tgl, hpd, force_local,
        input  online, rst_out, freq_cnt, meas_valid, qual_cnt
    );

    modport slave (
        input  hdmi_tgl, hpd, force_local,
        output online, rst_out, freq_cnt, meas_valid, qual_cnt
    );
endinterface

// File: rtl/hdmi_clk_source_ctrl_edge_rate_meter.sv
// Counts synchronised hdmi_tgl transitions over fixed windows of the local
// clock and publishes the per-window count with a one-cycle valid pulse.
module edge_rate_meter #(
    parameter int WIN_CYCLES = 65536,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgl,
    output logic [CNT_W-1:0] freq_cnt,
    output logic [CNT_W-1:0] freq_cnt_next,
    output logic             meas_valid,
    output logic             win_end
);
    localparam int                WCNT_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ECNT_MAX  = '1;

    logic [2:0]        sync_reg;
    logic              tgl_prev_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0]  ecnt_reg;
    logic [CNT_W-1:0]  ecnt_next;
    logic [CNT_W-1:0]  freq_cnt_reg;
    logic              meas_valid_reg;
    logic              edge_seen;

    assign edge_seen = sync_reg[2] ^ tgl_prev_reg;
    assign win_end   = (wcnt_reg == WCNT_LAST);

    // Saturating count; a transition landing on win_end still belongs to
    // the window that is closing.
    always_comb begin
        ecnt_next = ecnt_reg;
        if (edge_seen && (ecnt_reg != ECNT_MAX)) begin
            ecnt_next = ecnt_reg + 1'b1;
        end
    end

    assign freq_cnt_next = ecnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg       <= '0;
            tgl_prev_reg   <= 1'b0;
            wcnt_reg       <= '0;
            ecnt_reg       <= '0;
            freq_cnt_reg   <= '0;
            meas_valid_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[1:0], tgl};
            tgl_prev_reg   <= sync_reg[2];
            meas_valid_reg <= win_end;
            if (win_end) begin
                wcnt_reg     <= '0;
                ecnt_reg     <= '0;
                freq_cnt_reg <= ecnt_next;
            end else begin
                wcnt_reg <= wcnt_reg + 1'b1;
                ecnt_reg <= ecnt_next;
            end
        end
    end

    assign freq_cnt   = freq_cnt_reg;
    assign meas_valid = meas_valid_reg;

endmodule

// File: rtl/hdmi_clk_source_ctrl.sv
// Qualifies the HDMI recovered clock and drives the BUFGMUX select, holding
// the downstream reset across every source change.
module hdmi_clk_source_ctrl
    import clk_src_pkg::*;
#(
    parameter int WIN_CYCLES    = 65536,
    parameter int CNT_W         = 16,
    parameter int MIN_CNT       = 600,
    parameter int MAX_CNT       = 950,
    parameter int QUAL_WINS     = 4,
    parameter int SETTLE_CYCLES = 256
) (
    input logic                  clk,
    input logic                  rst,
    hdmi_clk_source_ctrl_if.slave bus
);
    localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    QUAL_LAST   = 3'(QUAL_WINS);
    localparam logic [31:0]   MIN_L       = MIN_CNT;
    localparam logic [31:0]   MAX_L       = MAX_CNT;

    logic [1:0]       hpd_sync_reg;
    logic             hpd_s;
    logic [CNT_W-1:0] freq_cnt;
    logic [CNT_W-1:0] freq_cnt_next;
    logic             meas_valid;
    logic             win_end;
    logic             in_range;

    state_t           state_reg, state_next;
    logic             target_reg, target_next;
    logic [2:0]       qual_reg, qual_next;
    logic [SW-1:0]    settle_reg, settle_next;
    logic             online_reg, online_next;
    logic             rst_out_reg, rst_out_next;
    logic             go_switch;
    logic             go_target;

    edge_rate_meter #(
        .WIN_CYCLES (WIN_CYCLES),
        .CNT_W      (CNT_W)
    ) u_meter (
        .clk           (clk),
        .rst           (rst),
        .tgl           (bus.hdmi_tgl),
        .freq_cnt      (freq_cnt),
        .freq_cnt_next (freq_cnt_next),
        .meas_valid    (meas_valid),
        .win_end       (win_end)
    );

    assign hpd_s    = hpd_sync_reg[1];
    assign in_range = cnt_in_range(32'(freq_cnt_next), MIN_L, MAX_L) && hpd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpd_sync_reg <= '0;
            state_reg    <= SWITCH;
            target_reg   <= SRC_LOCAL;
            qual_reg     <= '0;
            settle_reg   <= SETTLE_LOAD;
            online_reg   <= 1'b0;
            rst_out_reg  <= 1'b1;
        end else begin
            hpd_sync_reg <= {hpd_sync_reg[0], bus.hpd};
            state_reg    <= state_next;
            target_reg   <= target_next;
            qual_reg     <= qual_next;
            settle_reg   <= settle_next;
            online_reg   <= online_next;
            rst_out_reg  <= rst_out_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        qual_next    = qual_reg;
        settle_next  = settle_reg;
        online_next  = online_reg;
        rst_out_next = rst_out_reg;
        go_switch    = 1'b0;
        go_target    = SRC_LOCAL;

        case (state_reg)
            OFFLINE: begin
                if (!bus.force_local && win_end && in_range) begin
                    if (QUAL_WINS == 1) begin
                        go_switch = 1'b1;
                        go_target = SRC_HDMI;
                    end else begin
                        state_next = QUALIFY;
                        qual_next  = 3'd1;
                    end
                end
            end
            QUALIFY: begin
                if (bus.force_local || !hpd_s) begin
                    state_next = OFFLINE;
                    qual_next  = '0;
                end else if (win_end) begin
                    if (!in_range) begin
                        state_next = OFFLINE;
                        qual_next  = '0;
                    end else if ((qual_reg + 3'd1) == QUAL_LAST) begin
                        go_switch = 1'b1;
                        go_target = SRC_HDMI;
                    end else begin
                        qual_next = qual_reg + 3'd1;
                    end
                end
            end
            ONLINE: begin
                // One bad window is enough to fall back; re-entry needs full qualification.
                if (bus.force_local || !hpd_s || (win_end && !in_range)) begin
                    go_switch = 1'b1;
                    go_target = SRC_LOCAL;
                end
            end
            SWITCH: begin
                if ((target_reg == SRC_HDMI) && (bus.force_local || !hpd_s)) begin
                    go_switch = 1'b1;
                    go_target = SRC_LOCAL;
                end else if (settle_reg == '0) begin
                    rst_out_next = 1'b0;
                    state_next   = (target_reg == SRC_HDMI) ? ONLINE : OFFLINE;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            default: begin
                state_next = OFFLINE;
            end
        endcase

        // The select and the downstream reset change on the same edge.
        if (go_switch) begin
            state_next   = SWITCH;
            target_next  = go_target;
            online_next  = go_target;
            rst_out_next = 1'b1;
            settle_next  = SETTLE_LOAD;
            qual_next    = '0;
        end
    end

    assign bus.online     = online_reg;
    assign bus.rst_out    = rst_out_reg;
    assign bus.qual_cnt   = qual_reg;
    assign bus.freq_cnt   = freq_cnt;
    assign bus.meas_valid = meas_valid;

endmodule
